// File: rtl/adc_multi_current_check_if.sv
// Interface for the multi-channel over-current monitor: configuration, the
// time-multiplexed ADC sample stream and the latched fault outputs.
interface adc_multi_current_check_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8,
  parameter int CH_W   = 2
);
  logic              bypass;
  logic              clear_fail;
  logic              pulse_cw_select;
  logic [DATA_W-1:0] pulse_limit;
  logic [DATA_W-1:0] cw_limit;
  logic [CNT_W-1:0]  trip_count;
  logic [NUM_CH-1:0] ch_enable;
  logic              adc_data_valid;
  logic [CH_W-1:0]   adc_ch;
  logic [DATA_W-1:0] adc_data;
  logic [NUM_CH-1:0] fail_ch;
  logic              current_limit_fail;
  logic [CH_W-1:0]   first_fail_ch;
  logic [DATA_W-1:0] first_fail_data;

  modport master (
    output bypass, clear_fail, pulse_cw_select, pulse_limit, cw_limit,
           trip_count, ch_enable, adc_data_valid, adc_ch, adc_data,
    input  fail_ch, current_limit_fail, first_fail_ch, first_fail_data
  );

  modport slave (
    input  bypass, clear_fail, pulse_cw_select, pulse_limit, cw_limit,
           trip_count, ch_enable, adc_data_valid, adc_ch, adc_data,
    output fail_ch, current_limit_fail, first_fail_ch, first_fail_data
  );
endinterface

// File: rtl/adc_multi_current_check.sv
// Multi-channel over-current monitor: debounces consecutive over-limit samples
// per channel and latches per-channel/summary fault plus first-fault capture.
module adc_multi_current_check #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8,
  parameter int CH_W   = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  adc_multi_current_check_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, TRIPPED} state_t;

  state_t                       state_q, state_d;
  logic                         valid_q;
  logic [CH_W-1:0]              ch_q;
  logic [DATA_W-1:0]            data_q;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            fail_ch_q, fail_ch_d;
  logic                         clf_q, clf_d;
  logic [CH_W-1:0]              first_ch_q, first_ch_d;
  logic [DATA_W-1:0]            first_data_q, first_data_d;

  logic [DATA_W-1:0]            limit;
  logic                         over;
  logic [CNT_W-1:0]             trip_thr;
  logic [NUM_CH-1:0]            hit;
  logic [NUM_CH-1:0]            trip_hit;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_inc;

  assign limit    = bus.pulse_cw_select ? bus.pulse_limit : bus.cw_limit;
  assign over     = data_q > limit;
  assign trip_thr = (bus.trip_count == '0) ? CNT_W'(1) : bus.trip_count;

  // Out-of-range tags never match any gi, so they are dropped implicitly.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W:0] run_len;
    assign run_len      = {1'b0, cnt_q[gi]} + (CNT_W+1)'(1);
    assign hit[gi]      = valid_q && (ch_q == CH_W'(gi)) && bus.ch_enable[gi];
    assign cnt_inc[gi]  = (&cnt_q[gi]) ? cnt_q[gi] : cnt_q[gi] + CNT_W'(1);
    assign trip_hit[gi] = hit[gi] && over && (run_len >= {1'b0, trip_thr});
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fail_ch_d    = fail_ch_q;
    clf_d        = clf_q;
    first_ch_d   = first_ch_q;
    first_data_d = first_data_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!bus.bypass) state_d = ARMED;
      end
      ARMED: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (trip_hit[i])                          cnt_d[i] = cnt_inc[i];
          else if (!bus.ch_enable[i] || bus.clear_fail) cnt_d[i] = '0;
          else if (hit[i])                          cnt_d[i] = over ? cnt_inc[i] : '0;
        end
        // A trip outranks a simultaneous clear or disarm request.
        if (|trip_hit) begin
          state_d      = TRIPPED;
          fail_ch_d    = trip_hit;
          clf_d        = 1'b1;
          first_ch_d   = ch_q;
          first_data_d = data_q;
        end else if (bus.bypass) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      TRIPPED: begin
        if (bus.clear_fail) begin
          state_d      = IDLE;
          cnt_d        = '0;
          fail_ch_d    = '0;
          clf_d        = 1'b0;
          first_ch_d   = '0;
          first_data_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      ch_q         <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      fail_ch_q    <= '0;
      clf_q        <= 1'b0;
      first_ch_q   <= '0;
      first_data_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= bus.adc_data_valid;
      ch_q         <= bus.adc_ch;
      data_q       <= bus.adc_data;
      cnt_q        <= cnt_d;
      fail_ch_q    <= fail_ch_d;
      clf_q        <= clf_d;
      first_ch_q   <= first_ch_d;
      first_data_q <= first_data_d;
    end
  end

  assign bus.fail_ch            = fail_ch_q;
  assign bus.current_limit_fail = clf_q;
  assign bus.first_fail_ch      = first_ch_q;
  assign bus.first_fail_data    = first_data_q;

endmodule

// File: tb/tb_adc_multi_current_check.sv
// Scoreboard bench for adc_multi_current_check: stimulus queues expected fault
// state with a due cycle, a monitor pops and compares on the falling edge.
module tb_adc_multi_current_check;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 3;

  logic clk;
  logic rstn;
  int   cyc;
  int   vectors;
  int   miscompares;

  typedef struct {
    int                due;
    string             name;
    logic [NUM_CH-1:0] fc;
    logic              clf;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  adc_multi_current_check_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .CH_W(CH_W)) bif ();

  adc_multi_current_check #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that has fallen due.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      vectors++;
      if (e.due < cyc) begin
        miscompares++;
        $display("FAIL %s: check missed (due %0d, now %0d)", e.name, e.due, cyc);
      end else if (bif.fail_ch !== e.fc || bif.current_limit_fail !== e.clf ||
                   bif.first_fail_ch !== e.ch || bif.first_fail_data !== e.data) begin
        miscompares++;
        $display("FAIL %s: got fail_ch=%b clf=%b ch=%0d data=%0d, want fail_ch=%b clf=%b ch=%0d data=%0d",
                 e.name, bif.fail_ch, bif.current_limit_fail, bif.first_fail_ch, bif.first_fail_data,
                 e.fc, e.clf, e.ch, e.data);
      end else begin
        $display("ok   %s: fail_ch=%b clf=%b ch=%0d data=%0d", e.name, bif.fail_ch,
                 bif.current_limit_fail, bif.first_fail_ch, bif.first_fail_data);
      end
    end
  end

  task automatic cycle(input logic v, input logic [CH_W-1:0] c, input logic [DATA_W-1:0] d);
    bif.adc_data_valid = v;
    bif.adc_ch         = c;
    bif.adc_data       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0);
  endtask

  task automatic expect_at(input int delay, input string nm, input logic [NUM_CH-1:0] fc,
                           input logic clf, input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] dat);
    exp_t x;
    x.due  = cyc + delay;
    x.name = nm;
    x.fc   = fc;
    x.clf  = clf;
    x.ch   = ch;
    x.data = dat;
    exp_q.push_back(x);
  endtask

  task automatic pulse_clear();
    bif.clear_fail = 1'b1;
    cycle(1'b0, '0, '0);
    bif.clear_fail = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn                = 1'b0;
    bif.bypass          = 1'b0;
    bif.clear_fail      = 1'b0;
    bif.pulse_cw_select = 1'b0;
    bif.pulse_limit     = 16'd200;
    bif.cw_limit        = 16'd1000;
    bif.trip_count      = 8'd3;
    bif.ch_enable       = 4'b1111;
    bif.adc_data_valid  = 1'b0;
    bif.adc_ch          = '0;
    bif.adc_data        = '0;
    idle(2);
    expect_at(0, "reset", 4'b0000, 1'b0, 3'd0, 16'd0);
    rstn = 1'b1;
    idle(2);

    // 1: three consecutive over-limit samples on ch1
    cycle(1'b1, 3'd1, 16'd1001);
    cycle(1'b1, 3'd1, 16'd1001);
    cycle(1'b1, 3'd1, 16'd1001);
    expect_at(0, "t1_latency", 4'b0000, 1'b0, 3'd0, 16'd0);
    expect_at(1, "t1_trip", 4'b0010, 1'b1, 3'd1, 16'd1001);
    idle(2);
    pulse_clear();
    expect_at(0, "t1_clear", 4'b0000, 1'b0, 3'd0, 16'd0);
    idle(2);

    // 2: run broken by an in-limit sample
    cycle(1'b1, 3'd1, 16'd1001);
    cycle(1'b1, 3'd1, 16'd1001);
    cycle(1'b1, 3'd1, 16'd999);
    cycle(1'b1, 3'd1, 16'd1001);
    cycle(1'b1, 3'd1, 16'd1001);
    idle(2);
    expect_at(0, "t2_run_reset", 4'b0000, 1'b0, 3'd0, 16'd0);
    pulse_clear();
    idle(1);

    // 3: interleaved channels keep their own runs
    cycle(1'b1, 3'd2, 16'd1200);
    cycle(1'b1, 3'd0, 16'd500);
    cycle(1'b1, 3'd2, 16'd1200);
    cycle(1'b1, 3'd0, 16'd500);
    cycle(1'b1, 3'd2, 16'd1200);
    expect_at(1, "t3_interleave", 4'b0100, 1'b1, 3'd2, 16'd1200);
    idle(2);
    pulse_clear();
    idle(2);

    // 4: equal-to-limit never trips, one above does
    bif.trip_count = 8'd1;
    for (int i = 0; i < 10; i++) cycle(1'b1, 3'd0, 16'd1000);
    idle(1);
    expect_at(0, "t4_equal", 4'b0000, 1'b0, 3'd0, 16'd0);
    cycle(1'b1, 3'd0, 16'd1001);
    expect_at(1, "t4_trip", 4'b0001, 1'b1, 3'd0, 16'd1001);
    idle(2);

    // 5: bypass holds a fault, clear rearms, disabled and out-of-range tags dropped
    bif.bypass = 1'b1;
    cycle(1'b1, 3'd0, 16'd2000);
    cycle(1'b1, 3'd2, 16'd2000);
    idle(1);
    expect_at(0, "t5_bypass_hold", 4'b0001, 1'b1, 3'd0, 16'd1001);
    pulse_clear();
    expect_at(0, "t5_clear", 4'b0000, 1'b0, 3'd0, 16'd0);
    cycle(1'b1, 3'd2, 16'd5000);
    cycle(1'b1, 3'd2, 16'd5000);
    idle(1);
    expect_at(0, "t5_idle_ignored", 4'b0000, 1'b0, 3'd0, 16'd0);
    bif.bypass = 1'b0;
    idle(2);
    bif.ch_enable = 4'b0111;
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'd3, 16'd65535);
    cycle(1'b1, 3'd4, 16'd65535);
    cycle(1'b1, 3'd5, 16'd65535);
    cycle(1'b1, 3'd7, 16'd65535);
    idle(1);
    expect_at(0, "t5_disabled_oor", 4'b0000, 1'b0, 3'd0, 16'd0);
    bif.ch_enable  = 4'b1111;
    bif.trip_count = 8'd2;
    cycle(1'b1, 3'd3, 16'd65535);
    idle(1);
    expect_at(0, "t5_ch3_first", 4'b0000, 1'b0, 3'd0, 16'd0);
    cycle(1'b1, 3'd3, 16'd65535);
    expect_at(1, "t5_ch3_trip", 4'b1000, 1'b1, 3'd3, 16'd65535);
    idle(2);
    pulse_clear();
    idle(2);

    // 7: clear in the same cycle as a trip -> trip wins
    bif.trip_count = 8'd1;
    cycle(1'b1, 3'd1, 16'd1001);
    pulse_clear();
    expect_at(0, "t7_trip_beats_clear", 4'b0010, 1'b1, 3'd1, 16'd1001);
    idle(1);
    expect_at(0, "t7_held", 4'b0010, 1'b1, 3'd1, 16'd1001);
    pulse_clear();
    idle(2);

    // 6: pulse limit, trip_count 0 acts as 1, then asynchronous reset
    bif.pulse_cw_select = 1'b1;
    bif.pulse_limit     = 16'd200;
    bif.cw_limit        = 16'd5000;
    bif.trip_count      = 8'd0;
    cycle(1'b1, 3'd2, 16'd300);
    expect_at(1, "t6_pulse_trip0", 4'b0100, 1'b1, 3'd2, 16'd300);
    idle(2);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    expect_at(0, "t6_async_reset", 4'b0000, 1'b0, 3'd0, 16'd0);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations still pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
